// File: rtl/valu_seq.sv
// rtl/valu_seq.sv - issue/collect sequencer around the vector ALU
// Slices a full-register op into OP_W beats and reassembles a tail-undisturbed result.
module valu_seq #(
    parameter int VLEN    = 128,
    parameter int OP_W    = 32,
    parameter int ALU_LAT = 1,
    localparam int VL_W   = $clog2(VLEN/8) + 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    output logic              ready,
    input  logic [3:0]        op_instr,
    input  logic [1:0]        vsew,
    input  logic [VL_W-1:0]   vl,
    input  logic [VLEN-1:0]   vs1_data,
    input  logic [VLEN-1:0]   vs2_data,
    input  logic [VLEN-1:0]   vd_old,
    output logic [3:0]        alu_op_instr,
    output logic [1:0]        alu_vsew,
    output logic [OP_W-1:0]   alu_op_A,
    output logic [OP_W-1:0]   alu_op_B,
    input  logic [OP_W-1:0]   alu_result,
    output logic              busy,
    output logic              done,
    output logic [VLEN-1:0]   vd_data
);
    localparam int BEATS   = VLEN / OP_W;
    localparam int BPB     = OP_W / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam int KW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NBW     = $clog2(BEATS) + 1;
    localparam int HW      = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [HW-1:0]   h_q, h_d;
    logic [NBW-1:0]  nb_q, nb_d;
    logic [3:0]      op_q, op_d;
    logic [1:0]      sew_q, sew_d;
    logic [VL_W-1:0] vl_q, vl_d;
    logic [VLEN-1:0] vs1_q, vs1_d;
    logic [VLEN-1:0] vs2_q, vs2_d;
    logic [VLEN-1:0] old_q, old_d;
    logic [VLEN-1:0] vd_q, vd_d;

    logic [VL_W-1:0] vl_max, vl_eff;
    logic [VL_W:0]   vl_round;
    logic [2:0]      epb_sh;
    logic [NBW-1:0]  nb_in;
    logic            capture;
    logic            last;

    // Element count clamp and beat count for the incoming request; reserved SEW means no elements.
    always_comb begin
        vl_max = '0;
        case (vsew)
            2'b00:   vl_max = VL_W'(VLEN / 8);
            2'b01:   vl_max = VL_W'(VLEN / 16);
            2'b10:   vl_max = VL_W'(VLEN / 32);
            default: vl_max = '0;
        endcase
        vl_eff   = (vl > vl_max) ? vl_max : vl;
        epb_sh   = 3'(LOG_BPB) - {1'b0, vsew};
        vl_round = {1'b0, vl_eff} + ((VL_W+1)'(1) << epb_sh) - (VL_W+1)'(1);
        nb_in    = (vsew == 2'b11) ? '0 : NBW'(vl_round >> epb_sh);
    end

    assign last = (NBW'(k_q) == nb_q - NBW'(1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        h_d     = h_q;
        nb_d    = nb_q;
        op_d    = op_q;
        sew_d   = sew_q;
        vl_d    = vl_q;
        vs1_d   = vs1_q;
        vs2_d   = vs2_q;
        old_d   = old_q;
        vd_d    = vd_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op_instr;
                    sew_d = vsew;
                    vl_d  = vl_eff;
                    vs1_d = vs1_data;
                    vs2_d = vs2_data;
                    old_d = vd_old;
                    nb_d  = nb_in;
                    k_d   = '0;
                    h_d   = '0;
                    if (nb_in == '0) begin
                        vd_d    = vd_old;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (h_q == HW'(ALU_LAT)) begin
                    h_d     = '0;
                    capture = 1'b1;
                    if (last) state_d = S_DONE;
                    else      k_d     = k_q + KW'(1);
                end else begin
                    h_d = h_q + HW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Byte-wise merge: active elements from the ALU, tail from the old destination.
        // The final capture also fills the never-issued beats from the old destination.
        if (capture) begin
            for (int b = 0; b < BEATS; b++) begin
                for (int i = 0; i < BPB; i++) begin
                    if (b == int'(k_q)) begin
                        vd_d[(b*BPB+i)*8 +: 8] = (((b*BPB+i) >> sew_q) < int'(vl_q)) ?
                                                  alu_result[i*8 +: 8] : old_q[(b*BPB+i)*8 +: 8];
                    end else if (last && b > int'(k_q)) begin
                        vd_d[(b*BPB+i)*8 +: 8] = old_q[(b*BPB+i)*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            h_q     <= '0;
            nb_q    <= '0;
            op_q    <= '0;
            sew_q   <= '0;
            vl_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            old_q   <= '0;
            vd_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            h_q     <= h_d;
            nb_q    <= nb_d;
            op_q    <= op_d;
            sew_q   <= sew_d;
            vl_q    <= vl_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            old_q   <= old_d;
            vd_q    <= vd_d;
        end
    end

    assign ready        = (state_q == S_IDLE);
    assign busy         = (state_q == S_ISSUE) || (state_q == S_DONE);
    assign done         = (state_q == S_DONE);
    assign vd_data      = vd_q;
    assign alu_op_instr = op_q;
    assign alu_vsew     = sew_q;
    assign alu_op_A     = (state_q == S_ISSUE) ? vs1_q[int'(k_q)*OP_W +: OP_W] : '0;
    assign alu_op_B     = (state_q == S_ISSUE) ? vs2_q[int'(k_q)*OP_W +: OP_W] : '0;
endmodule

// File: tb/tb_valu_seq.sv
// tb/tb_valu_seq.sv - scoreboard bench for valu_seq with a one-cycle model ALU
module tb_valu_seq;
    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic         ready;
    logic [3:0]   op_instr = '0;
    logic [1:0]   vsew = '0;
    logic [4:0]   vl = '0;
    logic [127:0] vs1_data = '0, vs2_data = '0, vd_old = '0;
    logic [3:0]   alu_op_instr;
    logic [1:0]   alu_vsew;
    logic [31:0]  alu_op_A, alu_op_B;
    logic [31:0]  alu_result = '0;
    logic         busy, done;
    logic [127:0] vd_data;

    valu_seq #(.VLEN(128), .OP_W(32), .ALU_LAT(1)) dut (
        .clk(clk), .nrst(nrst), .start(start), .ready(ready),
        .op_instr(op_instr), .vsew(vsew), .vl(vl),
        .vs1_data(vs1_data), .vs2_data(vs2_data), .vd_old(vd_old),
        .alu_op_instr(alu_op_instr), .alu_vsew(alu_vsew),
        .alu_op_A(alu_op_A), .alu_op_B(alu_op_B), .alu_result(alu_result),
        .busy(busy), .done(done), .vd_data(vd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [1:0]   sew;
        logic [4:0]   vl;
        logic [127:0] a, b, old, exp;
        int           lat;
        bit           hold;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [127:0] exp_q[$];
    int           lat_q[$];
    logic [127:0] last_vd = '0;
    logic         prev_ready = 1'b1;
    logic         prev_done = 1'b0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Lane-wise model ALU: op 0 adds per SEW lane, op 1 is bitwise xor.
    function automatic logic [31:0] alu_f(logic [3:0] op, logic [1:0] sew, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        r = '0;
        if (op == 4'd1) r = a ^ b;
        else begin
            case (sew)
                2'b00: for (int i = 0; i < 4; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
                2'b01: for (int i = 0; i < 2; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
                2'b10: r = a + b;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        alu_result <= alu_f(alu_op_instr, alu_vsew, alu_op_A, alu_op_B);
    end

    always @(negedge clk) begin
        if (!nrst) begin
            last_vd    = '0;
            prev_ready = 1'b1;
            prev_done  = 1'b0;
        end else begin
            if (prev_ready && !ready) acc_cyc = cyc;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_done: got done=1 want no pending op");
                end else begin
                    chk("vd_data", vd_data, exp_q.pop_front());
                    chk("latency", 128'(cyc - acc_cyc + 1), 128'(lat_q.pop_front()));
                end
                last_vd = vd_data;
            end
            if (prev_done && done) chk("done_width", 128'(2), 128'(1));
            if (ready || done) chk("alu_idle_ops", {64'd0, alu_op_A, alu_op_B}, 128'd0);
            if (ready) chk("vd_hold", vd_data, last_vd);
            prev_ready = ready;
            prev_done  = done;
        end
    end

    task automatic send(input vec_t v, input bit expect_done);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ready && t < 100);
        if (!ready) chk("ready_timeout", 128'(0), 128'(1));
        op_instr = v.op;
        vsew     = v.sew;
        vl       = v.vl;
        vs1_data = v.a;
        vs2_data = v.b;
        vd_old   = v.old;
        start    = 1'b1;
        if (expect_done) begin
            exp_q.push_back(v.exp);
            lat_q.push_back(v.lat);
        end
        @(posedge clk);
        if (v.hold) repeat (4) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'd0, 2'b00, 5'd16, {16{8'h01}}, {16{8'h02}}, 128'd0, {16{8'h03}}, 9, 1'b1};
        vecs[1] = '{4'd0, 2'b00, 5'd5, {16{8'h10}}, {16{8'h01}}, {16{8'hAA}},
                    128'hAAAAAAAA_AAAAAAAA_AAAAAA11_11111111, 5, 1'b0};
        vecs[2] = '{4'd0, 2'b10, 5'd3, 128'h00000004_00000003_00000002_00000001,
                    128'h00000040_00000030_00000020_00000010,
                    128'hDEADBEEF_55555555_55555555_55555555,
                    128'hDEADBEEF_00000033_00000022_00000011, 7, 1'b0};
        vecs[3] = '{4'd0, 2'b01, 5'd8, {8{16'hFFFF}}, {8{16'h0002}}, {16{8'h77}}, {8{16'h0001}}, 9, 1'b0};
        vecs[4] = '{4'd0, 2'b00, 5'd0, {16{8'h01}}, {16{8'h01}},
                    128'h0123456789ABCDEF_FEDCBA9876543210,
                    128'h0123456789ABCDEF_FEDCBA9876543210, 1, 1'b0};
        vecs[5] = '{4'd0, 2'b11, 5'd8, {16{8'h01}}, {16{8'h01}},
                    128'h11112222_33334444_55556666_77778888,
                    128'h11112222_33334444_55556666_77778888, 1, 1'b0};
        vecs[6] = '{4'd1, 2'b10, 5'd16, {4{32'hF0F0F0F0}}, {4{32'hFF00FF00}}, 128'd0, {4{32'h0FF00FF0}}, 9, 1'b0};
        vecs[7] = '{4'd0, 2'b01, 5'd3, {8{16'h1000}}, {8{16'h0234}}, {8{16'hBBBB}},
                    128'hBBBBBBBB_BBBBBBBB_BBBB1234_12341234, 5, 1'b0};
        vecs[8] = '{4'd0, 2'b00, 5'd16, {16{8'h01}}, {16{8'h02}}, 128'd0, {16{8'h03}}, 9, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", {123'd0, ready, busy, done, 2'b00}, {123'd0, 1'b1, 1'b0, 1'b0, 2'b00});
        chk("reset_vd", vd_data, 128'd0);
        chk("reset_alu", {70'd0, alu_op_instr, alu_vsew, alu_op_A, alu_op_B}, 128'd0);
        nrst = 1'b1;

        for (int i = 0; i < 8; i++) send(vecs[i], 1'b1);
        drain();

        // Abort during beat 2 of a full-length op; no done may follow.
        send(vecs[8], 1'b0);
        repeat (4) @(posedge clk);
        #1 nrst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_flags", {125'd0, ready, busy, done}, {125'd0, 1'b1, 1'b0, 1'b0});
        chk("abort_vd", vd_data, 128'd0);
        chk("abort_alu_a", 128'(alu_op_A), 128'd0);
        nrst = 1'b1;
        repeat (20) @(posedge clk);

        send(vecs[1], 1'b1);
        drain();
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
